key_scan_ctrl: RTL

KEY_SCAN_CTRL -- requirements
Module: key_scan_ctrl

---
 rtl/key_scan_ctrl_pkg.sv | 18 +
 rtl/key_scan_ctrl_rr_pick.sv | 31 +++
 rtl/key_scan_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/key_scan_ctrl_pkg.sv
// Shared types and constants for the debounced key scanner.
package key_scan_ctrl_pkg;

   localparam int unsigned CNT_W         = 32;
   localparam int unsigned TIMES_DEFAULT = 20_000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_COMMIT = 2'd2
   } state_e;

   // Index width for N buttons; at least one bit so N=1 still has a usable index.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/key_scan_ctrl_rr_pick.sv
// Round-robin pick: first set bit of pend at or after ptr, wrapping modulo N.
module rr_pick #(
   parameter int unsigned N  = 5,
   parameter int unsigned IW = 3
) (
   input  logic [N-1:0]  pend,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx_c,
   output logic          valid_c
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [IW-1:0]  off;
   logic [IW:0]    sum;

   always_comb begin
      dbl     = {pend, pend} >> ptr;
      rot     = dbl[N-1:0];
      off     = '0;
      valid_c = |pend;
      // Descending scan so the lowest rotated offset wins.
      for (int k = int'(N) - 1; k >= 0; k--) begin
         if (rot[k]) off = IW'(k);
      end
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= (IW+1)'(N)) idx_c = IW'(sum - (IW+1)'(N));
      else                   idx_c = IW'(sum);
   end

endmodule

// File: rtl/key_scan_ctrl.sv
// N-button debouncer sharing one settle counter; buttons are served one at a time
// in round-robin order and a rising debounced level emits a one-cycle pulse.
module key_scan_ctrl
   import key_scan_ctrl_pkg::*;
#(
   parameter int unsigned N     = 5,
   parameter int unsigned TIMES = TIMES_DEFAULT
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [N-1:0] x,
   output logic [N-1:0] y,
   output logic [N-1:0] pos,
   output logic         busy
);

   localparam int unsigned  IW       = idx_w(N);
   localparam logic [CNT_W-1:0] TIMES_M1 = CNT_W'(TIMES - 1);

   logic [N-1:0]     sync1_q, sync2_q;
   logic [N-1:0]     y_q, y_d;
   logic [N-1:0]     pos_q, pos_d;
   logic             busy_q, busy_d;
   state_e           state_q, state_d;
   logic [IW-1:0]    sel_q, sel_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic             lvl_q, lvl_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [N-1:0]     pend_c;
   logic [IW-1:0]    pick_idx_c;
   logic             pick_valid_c;

   assign pend_c = sync2_q ^ y_q;

   rr_pick #(.N(N), .IW(IW)) u_pick (
      .pend    (pend_c),
      .ptr     (ptr_q),
      .idx_c   (pick_idx_c),
      .valid_c (pick_valid_c)
   );

   // Two-flop synchronizer for the raw button levels.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= x;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         ptr_q   <= '0;
         lvl_q   <= 1'b0;
         cnt_q   <= '0;
         y_q     <= '0;
         pos_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         lvl_q   <= lvl_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         pos_q   <= pos_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      lvl_d   = lvl_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      pos_d   = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (pick_valid_c) begin
               sel_d   = pick_idx_c;
               lvl_d   = sync2_q[pick_idx_c];
               cnt_d   = TIMES_M1;
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            // A bounce on the selected button restarts the settle window.
            if (sync2_q[sel_q] != lvl_q) begin
               lvl_d = sync2_q[sel_q];
               cnt_d = TIMES_M1;
            end else if (cnt_q == '0) begin
               state_d = ST_COMMIT;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_COMMIT: begin
            y_d[sel_q]   = lvl_q;
            pos_d[sel_q] = lvl_q & ~y_q[sel_q];
            ptr_d        = (sel_q == IW'(N - 1)) ? '0 : sel_q + IW'(1);
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   assign y    = y_q;
   assign pos  = pos_q;
   assign busy = busy_q;

endmodule
